// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
//
// Instruction fetch front-end. Owns the program counter, issues word
// addresses to a synchronous-read instruction ROM (one-cycle latency, at most
// one read outstanding), buffers returned instructions with their PC in a
// small FIFO and hands them to decode over a valid/ready handshake. A redirect
// pulse reloads the PC and flushes both the FIFO and any in-flight read.
//
// Parameters:
//   RESET_PC   byte address of the first fetch after reset (word aligned)
//   FIFO_DEPTH entries in the {pc, inst} output buffer, 2..8
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   rom_addr, rom_en       ROM word index and read enable (issue cycle)
//   rom_inst               ROM data, valid the cycle after rom_en
//   redirect_valid/_pc     one-cycle PC reload request and byte target
//   out_valid/_ready       decode handshake for the FIFO head
//   out_inst, out_pc       FIFO head instruction and its byte PC
//   misalign_err           sticky misaligned-redirect flag
//
// Build option: define FETCH_ALIGN_CHECK_EN to build the misaligned-redirect
// check; otherwise misalign_err is tied low.

module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] rom_addr,
    output logic        rom_en,
    input  logic [31:0] rom_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        misalign_err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   fetch_pc;
    logic          vld_p1;
    logic [31:0]   pc_p1;
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [31:0]   fifo_inst [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          pop;
    logic          push;
    logic          issue;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;

    // Occupancy after this cycle's pop, counting the read still in flight, so
    // an issued read always has a FIFO slot waiting for it.
    assign occupancy = {1'b0, count} + (CW+1)'(vld_p1) - (CW+1)'(pop);

    // rst_n gating keeps rom_en low while reset is held (fetch_pc is already
    // at RESET_PC, so the raw issue condition would otherwise be true).
    assign issue    = rst_n & ~redirect_valid & (occupancy < (CW+1)'(FIFO_DEPTH));
    assign push     = vld_p1 & ~redirect_valid;
    assign rom_en   = issue;
    assign rom_addr = {2'b00, fetch_pc[31:2]};

    assign out_pc   = out_valid ? fifo_pc[rd_ptr]   : 32'h0;
    assign out_inst = out_valid ? fifo_inst[rd_ptr] : 32'h0;

    // Stage p0 -> p1: PC counter, in-flight flag and FIFO bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            vld_p1   <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_valid) begin
            // A same-cycle pop is honoured implicitly: the whole FIFO is
            // discarded, including the entry decode just took.
            fetch_pc <= redirect_pc & ~32'h3;
            vld_p1   <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            vld_p1 <= issue;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Stage p1 -> FIFO: issued PC travels with the read; returned data is
    // written at the tail. Data storage carries no reset.
    always_ff @(posedge clk) begin
        if (issue) begin
            pc_p1 <= fetch_pc;
        end
        if (push) begin
            fifo_pc[wr_ptr]   <= pc_p1;
            fifo_inst[wr_ptr] <= rom_inst;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Testbench for inst_fetch_unit: directed scenarios followed by randomized
// handshake/redirect traffic. The reference model is the architectural
// instruction stream: consecutive word PCs from the current start address,
// restarted at every redirect or reset, with inst = pc ^ 32'hA5A5_0000.
module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          FIFO_DEPTH = 2;
    localparam logic [31:0] INST_KEY   = 32'hA5A5_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] rom_addr;
    logic        rom_en;
    logic [31:0] rom_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        misalign_err;

    int          checks;
    int          failures;
    int          accepts;
    logic [31:0] exp_q [$];
    logic [31:0] gen_pc;
    logic        mis_model;

    inst_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_en         (rom_en),
        .rom_inst       (rom_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data for the address presented with rom_en appears the
    // next cycle; idle cycles return noise so unexpected captures show up.
    always @(posedge clk) begin
        if (rom_en) rom_inst <= {rom_addr[29:0], 2'b00} ^ INST_KEY;
        else        rom_inst <= $urandom();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refill();
        while (exp_q.size() < 16) begin
            exp_q.push_back(gen_pc);
            gen_pc = gen_pc + 32'd4;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        refill();
    endtask

    // Monitor: every accepted head must be the next PC of the model stream.
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                accepts++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL accept_unexpected: got pc %h expected no output", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pc", out_pc, e);
                    chk("out_inst", out_inst, e ^ INST_KEY);
                end
            end
            chk("misalign_err", {31'h0, misalign_err}, {31'h0, mis_model});
        end
    end

    // Called at posedge+1; one redirect cycle, model restarts after its edge.
    task automatic do_redirect(input logic [31:0] tgt, input logic rdy);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        out_ready      = rdy;
        #1;
        chk("redirect_rom_en", {31'h0, rom_en}, 32'h0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        exp_q.delete();
        gen_pc = tgt & ~32'h3;
`ifdef FETCH_ALIGN_CHECK_EN
        if (tgt[1:0] != 2'b00) mis_model = 1'b1;
`endif
        refill();
    endtask

    // Redirect then verify the restart timing and ROM addressing.
    task automatic redirect_and_check(input logic [31:0] tgt, input logic rdy);
        logic [31:0] base;
        base = tgt & ~32'h3;
        do_redirect(tgt, rdy);
        @(negedge clk);
        chk("rdr_valid_c1", {31'h0, out_valid}, 32'h0);
        chk("rdr_addr_c1", rom_addr, {2'b00, base[31:2]});
        step();
        @(negedge clk);
        chk("rdr_valid_c2", {31'h0, out_valid}, 32'h0);
        chk("rdr_addr_c2", rom_addr, {2'b00, base[31:2]} + 32'd1 & 32'h3FFF_FFFF);
        step();
        @(negedge clk);
        chk("rdr_valid_c3", {31'h0, out_valid}, 32'h1);
        chk("rdr_pc_c3", out_pc, base);
        chk("rdr_addr_c3", rom_addr, ({2'b00, base[31:2]} + 32'd2) & 32'h3FFF_FFFF);
    endtask

    // Called at posedge+1 with reset held.
    task automatic release_and_check();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        refill();
        @(negedge clk);
        chk("rel_rom_en", {31'h0, rom_en}, 32'h1);
        chk("rel_addr", rom_addr, {2'b00, RESET_PC[31:2]});
        chk("rel_valid_c0", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        chk("rel_valid_c1", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        chk("rel_valid_c2", {31'h0, out_valid}, 32'h1);
        chk("rel_pc_c2", out_pc, RESET_PC);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'h0, out_valid}, 32'h0);
        chk({tag, "_pc"}, out_pc, 32'h0);
        chk({tag, "_inst"}, out_inst, 32'h0);
        chk({tag, "_rom_en"}, {31'h0, rom_en}, 32'h0);
        chk({tag, "_rom_addr"}, rom_addr, {2'b00, RESET_PC[31:2]});
        chk({tag, "_misalign"}, {31'h0, misalign_err}, 32'h0);
    endtask

    initial begin
        logic [31:0] held_pc;
        logic [31:0] held_inst;
        logic [31:0] tgt;
        checks = 0; failures = 0; accepts = 0;
        rst_n = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        gen_pc = RESET_PC; mis_model = 1'b0;
        held_pc = 32'h0; held_inst = 32'h0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        step();
        release_and_check();

        // Steady stream: one instruction per cycle.
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            chk("steady_valid", {31'h0, out_valid}, 32'h1);
        end

        // Decode stall: FIFO fills, issue stops, head holds.
        step();
        out_ready = 1'b0;
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            if (s == 0) begin
                held_pc   = out_pc;
                held_inst = out_inst;
            end
            chk("stall_valid", {31'h0, out_valid}, 32'h1);
            chk("stall_pc_hold", out_pc, held_pc);
            chk("stall_inst_hold", out_inst, held_inst);
            if (s >= FIFO_DEPTH - 1) chk("stall_rom_en", {31'h0, rom_en}, 32'h0);
            step();
        end
        out_ready = 1'b1;
        repeat (4) step();

        // Redirect with fetch in flight and FIFO occupied, no pop.
        redirect_and_check(32'h0000_0100, 1'b0);
        repeat (3) step();
        // Redirect coinciding with an accepted head.
        redirect_and_check(32'h0000_0300, 1'b1);
        repeat (3) step();
        // PC wrap at the top of the address space.
        redirect_and_check(32'hFFFF_FFF8, 1'b1);
        repeat (4) step();
        // Back-to-back redirects: only the last target survives.
        do_redirect(32'h0000_0500, 1'b1);
        redirect_and_check(32'h0000_0700, 1'b1);
        repeat (3) step();
        // Misaligned target: low bits dropped.
        redirect_and_check(32'h0000_0202, 1'b1);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("misalign_set", {31'h0, misalign_err}, 32'h1);
`else
        chk("misalign_tied", {31'h0, misalign_err}, 32'h0);
`endif
        repeat (3) step();

        // Randomized handshake and redirect traffic.
        for (int c = 0; c < 1500; c++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4;
                    1:       tgt = ($urandom() & 32'h0000_FFFC) | 32'($urandom_range(1, 3));
                    default: tgt = $urandom() & 32'hFFFF_FFFC;
                endcase
                do_redirect(tgt, ($urandom_range(0, 1) == 1));
            end else begin
                step();
            end
        end

        // Reset in the middle of traffic.
        out_ready = 1'b1;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        gen_pc    = RESET_PC;
        mis_model = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        release_and_check();
        repeat (8) step();

        chk("progress", {31'h0, (accepts > 300)}, 32'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
